// File: rtl/axi_lite_write_arbiter_pkg.sv
// Shared encodings for the AXI-Lite write arbiter: B response codes and FSM states.
package axi_lite_write_arbiter_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/axi_lite_write_arbiter_rr.sv
// Combinational round-robin pick: first set request after last_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [GRANT_W-1:0] idx_o,
  output logic               any_o
);

  logic [GRANT_W-1:0] pos;

  // last_i itself is visited last, so a previous winner only wins when alone
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = GRANT_W'((int'(last_i) + k) % NUM_REQ);
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// Shares one AXI-Lite AW/W/B write port between NUM_REQ requesters, round-robin,
// one outstanding write at a time.
module axi_lite_write_arbiter
  import axi_lite_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int WRITE_STROBE = DATA_SIZE / 8,
  parameter int GRANT_W      = $clog2(NUM_REQ)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_address,
  input  logic [NUM_REQ*DATA_SIZE-1:0]    req_data,
  input  logic [NUM_REQ*WRITE_STROBE-1:0] req_strobe,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [1:0]                      req_response,
  output logic [GRANT_W-1:0]              grant_index,
  output logic                            busy,
  output logic [ADDRESS_SIZE-1:0]         write_address,
  output logic                            write_address_valid,
  input  logic                            write_address_ready,
  output logic [DATA_SIZE-1:0]            write_data,
  output logic [WRITE_STROBE-1:0]         write_data_strobe,
  output logic                            write_data_valid,
  input  logic                            write_data_ready,
  input  logic [1:0]                      write_response,
  input  logic                            write_response_valid,
  output logic                            write_response_ready
);

  logic [NUM_REQ-1:0][ADDRESS_SIZE-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0]    data_a;
  logic [NUM_REQ-1:0][WRITE_STROBE-1:0] strb_a;

  assign addr_a = req_address;
  assign data_a = req_data;
  assign strb_a = req_strobe;

  state_e             state_q;
  logic [GRANT_W-1:0] last_q;
  logic [NUM_REQ-1:0] gnt_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [GRANT_W-1:0] arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q              <= ST_IDLE;
      last_q               <= GRANT_W'(NUM_REQ - 1);
      gnt_q                <= '0;
      req_done             <= '0;
      req_response         <= AXI_RESP_OKAY;
      grant_index          <= '0;
      busy                 <= 1'b0;
      write_address        <= '0;
      write_address_valid  <= 1'b0;
      write_data           <= '0;
      write_data_strobe    <= '0;
      write_data_valid     <= 1'b0;
      write_response_ready <= 1'b0;
    end else begin
      req_done <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_index         <= arb_idx;
            gnt_q               <= arb_gnt;
            write_address       <= addr_a[arb_idx];
            write_data          <= data_a[arb_idx];
            write_data_strobe   <= strb_a[arb_idx];
            write_address_valid <= 1'b1;
            write_data_valid    <= 1'b1;
            busy                <= 1'b1;
            state_q             <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // AW and W retire independently; a channel already done counts as complete
          if (write_address_ready) write_address_valid <= 1'b0;
          if (write_data_ready)    write_data_valid    <= 1'b0;
          if ((!write_address_valid || write_address_ready) &&
              (!write_data_valid || write_data_ready)) begin
            write_response_ready <= 1'b1;
            state_q              <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (write_response_valid) begin
            req_response         <= write_response;
            write_response_ready <= 1'b0;
            req_done             <= gnt_q;
            busy                 <= 1'b0;
            state_q              <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_q  <= grant_index;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Directed + randomized bench for axi_lite_write_arbiter with a configurable AXI-Lite slave.
module tb_axi_lite_write_arbiter;
  import axi_lite_write_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AS = 32;
  localparam int DS = 32;
  localparam int WS = 4;
  localparam int GW = 2;

  logic aclk   = 1'b0;
  logic areset = 1'b1;

  logic [N-1:0]         req_valid;
  logic [N-1:0][AS-1:0] addr_a;
  logic [N-1:0][DS-1:0] data_a;
  logic [N-1:0][WS-1:0] strb_a;
  logic [N-1:0]         req_done;
  logic [1:0]           req_response;
  logic [GW-1:0]        grant_index;
  logic                 busy;
  logic [AS-1:0]        write_address;
  logic                 write_address_valid, write_address_ready;
  logic [DS-1:0]        write_data;
  logic [WS-1:0]        write_data_strobe;
  logic                 write_data_valid, write_data_ready;
  logic [1:0]           write_response;
  logic                 write_response_valid, write_response_ready;

  always #5 aclk = ~aclk;

  axi_lite_write_arbiter #(.NUM_REQ(N), .ADDRESS_SIZE(AS), .DATA_SIZE(DS)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_address(addr_a), .req_data(data_a), .req_strobe(strb_a),
    .req_done(req_done), .req_response(req_response), .grant_index(grant_index), .busy(busy),
    .write_address(write_address), .write_address_valid(write_address_valid),
    .write_address_ready(write_address_ready),
    .write_data(write_data), .write_data_strobe(write_data_strobe),
    .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .write_response(write_response), .write_response_valid(write_response_valid),
    .write_response_ready(write_response_ready)
  );

  // ---------------- slave (owned by this process only) ----------------
  int            aw_dly, w_dly;
  logic          early_b;
  logic [1:0]    resp_cfg;
  int            aw_cnt, w_cnt;
  logic          aw_got, w_got, b_fire;
  logic [AS-1:0] aw_log [$];
  logic [DS+WS-1:0] w_log [$];

  initial begin : slave
    write_address_ready = 1'b0; write_data_ready = 1'b0;
    write_response_valid = 1'b0; write_response = 2'b00;
    aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0; b_fire = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        write_address_ready = 1'b0; write_data_ready = 1'b0; write_response_valid = 1'b0;
        aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0; b_fire = 1'b0;
      end else begin
        if (b_fire) begin
          write_response_valid = 1'b0; b_fire = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        end else begin
          if (!write_response_valid &&
              (early_b ? (aw_got || write_address_valid) : (aw_got && w_got))) begin
            write_response_valid = 1'b1;
            write_response = resp_cfg;
          end
          if (write_response_valid && write_response_ready) b_fire = 1'b1;
        end
        if (write_address_valid) begin
          if (aw_cnt >= aw_dly) begin
            write_address_ready = 1'b1; aw_log.push_back(write_address); aw_got = 1'b1; aw_cnt = 0;
          end else begin
            write_address_ready = 1'b0; aw_cnt++;
          end
        end else begin
          write_address_ready = 1'b0; aw_cnt = 0;
        end
        if (write_data_valid) begin
          if (w_cnt >= w_dly) begin
            write_data_ready = 1'b1; w_log.push_back({write_data, write_data_strobe}); w_got = 1'b1; w_cnt = 0;
          end else begin
            write_data_ready = 1'b0; w_cnt++;
          end
        end else begin
          write_data_ready = 1'b0; w_cnt = 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0, passed = 0, failed = 0;
  int m_last;
  int aw_rd = 0, w_rd = 0;
  int t_g, t_lat, t_aw, t_w, t_br, t_early;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: scan last+1, last+2, ... modulo N.
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(m_last + k) % N]) return (m_last + k) % N;
    return 0;
  endfunction

  // Runs one write from IDLE to its done pulse and checks it against the model.
  task automatic txn(input logic drop, input logic keep);
    int bad;
    logic [63:0] o;
    t_g = pick(req_valid);
    t_lat = 0; t_aw = 0; t_w = 0; t_br = 0; t_early = 0; bad = 0;
    do begin
      @(negedge aclk); #1;
      t_lat++;
      if (drop && t_lat == 1) req_valid[t_g] = 1'b0;
      if (write_address_valid) begin
        t_aw = t_lat;
        if (write_address !== addr_a[t_g]) bad++;
      end
      if (write_data_valid) begin
        t_w = t_lat;
        if ({write_data, write_data_strobe} !== {data_a[t_g], strb_a[t_g]}) bad++;
      end
      if (write_response_ready && t_br == 0) t_br = t_lat;
      if (write_response_ready && (write_address_valid || write_data_valid)) bad++;
      if (write_response_valid && !write_response_ready) t_early++;
      if (req_done == '0 && busy !== 1'b1) bad++;
    end while (req_done == '0 && t_lat < 200);
    chk("done_onehot", 64'(req_done), 64'd1 << t_g);
    chk("response", 64'(req_response), 64'(resp_cfg));
    chk("grant_index", 64'(grant_index), 64'(t_g));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("protocol", 64'(bad), 64'd0);
    o = 'x; if (aw_rd < aw_log.size()) o = 64'(aw_log[aw_rd]); aw_rd++;
    chk("aw_payload", o, 64'(addr_a[t_g]));
    o = 'x; if (w_rd < w_log.size()) o = 64'(w_log[w_rd]); w_rd++;
    chk("w_payload", o, 64'({data_a[t_g], strb_a[t_g]}));
    m_last = t_g;
    if (!keep) req_valid[t_g] = 1'b0;
    @(negedge aclk); #1;
    chk("done_single_cycle", 64'(req_done), 64'd0);
  endtask

  int order [5] = '{1, 2, 3, 0, 1};

  initial begin : main
    req_valid = '0; addr_a = '0; data_a = '0; strb_a = '0;
    aw_dly = 0; w_dly = 0; early_b = 1'b0; resp_cfg = AXI_RESP_OKAY; m_last = N - 1;

    repeat (3) @(negedge aclk);
    #1;
    chk("rst_awvalid", 64'(write_address_valid), 64'd0);
    chk("rst_wvalid", 64'(write_data_valid), 64'd0);
    chk("rst_bready", 64'(write_response_ready), 64'd0);
    chk("rst_done", 64'(req_done), 64'd0);
    chk("rst_resp", 64'(req_response), 64'd0);
    chk("rst_grant", 64'(grant_index), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    areset = 1'b0;
    @(negedge aclk); #1;

    // single zero-wait write
    addr_a[0] = 32'h0; data_a[0] = 32'hDEADBEEF; strb_a[0] = 4'hF; req_valid = 4'b0001;
    txn(1'b0, 1'b0);
    chk("t1_latency", 64'(t_lat), 64'd3);
    chk("t1_aw_cycle", 64'(t_aw), 64'd1);
    chk("t1_w_cycle", 64'(t_w), 64'd1);
    chk("t1_bready_cycle", 64'(t_br), 64'd2);

    // round-robin with all requesters held
    for (int i = 0; i < N; i++) begin
      addr_a[i] = $urandom & 32'hFFFF_FFFC; data_a[i] = $urandom; strb_a[i] = 4'($urandom_range(0, 15));
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, 1'b1);
      chk("t2_order", 64'(t_g), 64'(order[i]));
    end
    req_valid = '0;
    @(negedge aclk); #1;

    // W delayed, then AW delayed
    w_dly = 3; req_valid = 4'b0100;
    txn(1'b0, 1'b0);
    chk("t3a_aw_last", 64'(t_aw), 64'd1);
    chk("t3a_w_last", 64'(t_w), 64'd4);
    chk("t3a_bready", 64'(t_br), 64'd5);
    w_dly = 0; aw_dly = 3; req_valid = 4'b1000;
    txn(1'b0, 1'b0);
    chk("t3b_aw_last", 64'(t_aw), 64'd4);
    chk("t3b_w_last", 64'(t_w), 64'd1);
    chk("t3b_bready", 64'(t_br), 64'd5);
    aw_dly = 0;

    // DECERR forwarded, then a normal write whose requester drops valid after grant
    addr_a[1] = 32'h4; resp_cfg = AXI_RESP_DECERR; req_valid = 4'b0010;
    txn(1'b0, 1'b0);
    resp_cfg = AXI_RESP_OKAY; req_valid = 4'b0001;
    txn(1'b1, 1'b0);

    // reset while AW is pending
    aw_dly = 100; w_dly = 100; req_valid = 4'b0100;
    @(negedge aclk); #1;
    chk("t5_awvalid_before", 64'(write_address_valid), 64'd1);
    areset = 1'b1;
    #1;
    chk("t5_awvalid_async", 64'(write_address_valid), 64'd0);
    chk("t5_wvalid_async", 64'(write_data_valid), 64'd0);
    chk("t5_busy_async", 64'(busy), 64'd0);
    req_valid = 4'b1111; m_last = N - 1;
    repeat (2) @(negedge aclk);
    #1;
    chk("t5_no_done", 64'(req_done), 64'd0);
    aw_dly = 0; w_dly = 0; areset = 1'b0;
    txn(1'b0, 1'b0);
    chk("t5_first_after_reset", 64'(t_g), 64'd0);
    req_valid = '0;
    @(negedge aclk); #1;

    // B offered before the W handshake
    early_b = 1'b1; w_dly = 3; req_valid = 4'b1000;
    txn(1'b0, 1'b0);
    chk("t6_early_b_cycles", 64'(t_early), 64'd4);
    chk("t6_bready", 64'(t_br), 64'd5);
    early_b = 1'b0; w_dly = 0;

    // randomized traffic
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) begin
        addr_a[i] = $urandom & 32'hFFFF_FFFC; data_a[i] = $urandom; strb_a[i] = 4'($urandom_range(0, 15));
      end
      req_valid = req_valid | 4'($urandom_range(0, 15));
      if (req_valid == '0) req_valid[$urandom_range(0, N - 1)] = 1'b1;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: resp_cfg = AXI_RESP_OKAY;
        1: resp_cfg = AXI_RESP_SLVERR;
        default: resp_cfg = AXI_RESP_DECERR;
      endcase
      txn($urandom_range(0, 3) == 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
